// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/fa_cell.sv
// Full adder from two half adders plus an OR; the only arithmetic in the serial adder.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1, c1, c2;

  assign s1 = x ^ y;
  assign c1 = x & y;
  assign s  = s1 ^ ci;
  assign c2 = s1 & ci;
  assign co = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder, LSB first, one sum bit per clock.
// Optional subtraction via SERIAL_ADDER_SUB_EN (adds the sub input).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, rb_q, sum_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;

  logic             load, last_bit, fa_s, fa_co;
  logic [WIDTH-1:0] b_load;
  logic             carry_init;

`ifdef SERIAL_ADDER_SUB_EN
  // a - b computed as a + ~b + 1; final carry of 1 means no borrow.
  assign b_load     = sub ? ~b : b;
  assign carry_init = sub;
`else
  assign b_load     = b;
  assign carry_init = 1'b0;
`endif

  assign load     = start & ((state_q == StIdle) | (state_q == StDone));
  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  fa_cell u_fa_cell (
    .x  (ra_q[0]),
    .y  (rb_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra_q    <= '0;
      rb_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (load) begin
      ra_q    <= a;
      rb_q    <= b_load;
      sum_q   <= '0;
      carry_q <= carry_init;
      cnt_q   <= '0;
    end else if (state_q == StRun) begin
      ra_q    <= ra_q >> 1;
      rb_q    <= rb_q >> 1;
      // After WIDTH shifts the first-computed bit lands in the LSB.
      sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
      carry_q <= fa_co;
      cnt_q   <= cnt_q + CntW'(1);
    end
  end

  assign sum  = sum_q;
  assign cout = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder with a queue-based scoreboard of expected results.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       sub_in;
  logic       busy, done, cout;
  logic [7:0] sum;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc, busy_cnt, n_done;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub_in),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (busy) busy_cnt++;
  endtask

  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
    if (s) return {1'b0, x} + {1'b0, ~y} + 9'd1;
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Drive an accepted start for one cycle and record the expected result.
  task automatic launch(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic [8:0] r;
    r = model(x, y, s);
    exp_q.push_back('{sum: r[7:0], cout: r[8]});
    start = 1'b1; a = x; b = y; sub_in = s;
    cyc = 0; busy_cnt = 0;
    tick();
    start = 1'b0; a = 8'h00; b = 8'h00; sub_in = 1'b0;
  endtask

  // Wait (bounded) for done, then check latency, busy length and result.
  task automatic finish_op(input string tag);
    exp_t e;
    while (!done && cyc < 40) tick();
    chk({tag, ".done_seen"}, 16'(done), 16'd1);
    chk({tag, ".latency"}, 16'(cyc), 16'd9);
    chk({tag, ".busy_cycles"}, 16'(busy_cnt), 16'd8);
    if (exp_q.size() == 0) begin
      chk({tag, ".scoreboard_empty"}, 16'd0, 16'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".sum"}, 16'(sum), 16'(e.sum));
      chk({tag, ".cout"}, 16'(cout), 16'(e.cout));
    end
  endtask

  // Confirm done is a single pulse and the result is held afterwards.
  task automatic check_hold(input string tag);
    logic [7:0] s0;
    logic       c0;
    s0 = sum; c0 = cout;
    tick();
    tick();
    chk({tag, ".done_pulse"}, 16'(done), 16'd0);
    chk({tag, ".sum_held"}, 16'(sum), 16'(s0));
    chk({tag, ".cout_held"}, 16'(cout), 16'(c0));
  endtask

  initial begin
    logic [7:0] ra, rb;
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; sub_in = 1'b0;
    cyc = 0; busy_cnt = 0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset.busy", 16'(busy), 16'd0);
    chk("reset.done", 16'(done), 16'd0);
    chk("reset.sum", 16'(sum), 16'd0);
    chk("reset.cout", 16'(cout), 16'd0);

    launch(8'h0F, 8'h01, 1'b0);
    finish_op("add_0f_01");
    check_hold("add_0f_01");

    launch(8'hFF, 8'h01, 1'b0);
    finish_op("add_ff_01");
    check_hold("add_ff_01");

    // Start during RUN must be ignored.
    launch(8'h03, 8'h04, 1'b0);
    tick();
    tick();
    start = 1'b1; a = 8'hAA; b = 8'h55;
    tick();
    start = 1'b0; a = 8'h00; b = 8'h00;
    finish_op("ignore_start");
    check_hold("ignore_start");

    // Reset mid-run abandons the operation without a done pulse.
    launch(8'h5A, 8'h3C, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("midrst.busy", 16'(busy), 16'd0);
    chk("midrst.sum", 16'(sum), 16'd0);
    chk("midrst.cout", 16'(cout), 16'd0);
    chk("midrst.done", 16'(done), 16'd0);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) n_done++;
    end
    chk("midrst.no_done", 16'(n_done), 16'd0);

    // Back-to-back: second start issued in the DONE cycle.
    launch(8'h10, 8'h20, 1'b0);
    finish_op("b2b_first");
    launch(8'h80, 8'h80, 1'b0);
    finish_op("b2b_second");
    check_hold("b2b_second");

    for (int i = 0; i < 3; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      launch(ra, rb, 1'b0);
      finish_op("rand_add");
    end

`ifdef SERIAL_ADDER_SUB_EN
    launch(8'h05, 8'h07, 1'b1);
    finish_op("sub_05_07");
    launch(8'h07, 8'h05, 1'b1);
    finish_op("sub_07_05");
    check_hold("sub_07_05");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
